// File: rtl/tof_pkg.sv
// ---------------------------------------------------------------------------
// tof_pkg
// Shared constants for the ToF frame writer: sensor count, zones per sensor,
// distance width, bit positions of the zone/distance fields inside the
// upstream data word, per-sensor counter width and the writer state encoding.
// ---------------------------------------------------------------------------
package tof_pkg;

  localparam int NUM_TOF  = 8;
  localparam int ZONES    = 64;
  localparam int DIST_W   = 16;

  // Field positions inside tof_data: [21:16] zone index, [15:0] distance.
  localparam int DIST_LSB = 0;
  localparam int DIST_MSB = 15;
  localparam int ZONE_LSB = 16;
  localparam int ZONE_MSB = 21;

  // Per-sensor word counter must reach ZONES (64), hence 7 bits.
  localparam int CNT_W    = 7;

  typedef enum logic [1:0] {
    ST_SCAN  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } fw_state_e;

endpackage

// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8
// Purely combinational round-robin pick over 8 requesters: returns the index
// of the first set request bit at or after ptr, wrapping 7 -> 0.
// Ports:
//   req   [7:0] request bits
//   ptr   [2:0] highest-priority index for this pick
//   grant [2:0] chosen index (0 when nothing requests)
//   valid       at least one request bit set
// ---------------------------------------------------------------------------
module rr_arbiter8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] grant,
  output logic       valid
);

  logic [2:0] idx_s;

  // Walk the offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    grant = 3'd0;
    valid = 1'b0;
    idx_s = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      idx_s = ptr + 3'(k);
      if (req[idx_s]) begin
        grant = idx_s;
        valid = 1'b1;
      end else begin
        grant = grant;
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/tof_frame_writer.sv
// ---------------------------------------------------------------------------
// tof_frame_writer
// Collects distance words from 8 ToF sensors into a BRAM frame of 8x64 words.
// A round-robin scan picks a pending sensor, the following cycle writes its
// word to {sensor, zone} and pops it. Once every sensor has delivered ZONES
// words the frame is held (frame_rdy) until the reader pulses frame_ack.
// Words arriving for a sensor that is already full are popped and counted
// in a saturating drop counter.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   tof_rdy   [7:0]   per-sensor word-pending level
//   tof_data  [21:0]  {zone[5:0], distance[15:0]} of sensor tof_sel
//   frame_ack         one-cycle pulse: frame consumed
//   tof_sel   [2:0]   sensor index for the upstream data mux
//   tof_ack   [7:0]   one-hot pop of the selected sensor
//   wea, addra, dina  BRAM port-A write
//   frame_rdy         frame complete level
//   drop_cnt  [7:0]   saturating count of discarded words
// ---------------------------------------------------------------------------
module tof_frame_writer #(
  parameter int NUM_TOF = tof_pkg::NUM_TOF,
  parameter int ZONES   = tof_pkg::ZONES,
  parameter int DIST_W  = tof_pkg::DIST_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_TOF-1:0] tof_rdy,
  input  logic [21:0]        tof_data,
  input  logic               frame_ack,
  output logic [2:0]         tof_sel,
  output logic [NUM_TOF-1:0] tof_ack,
  output logic               wea,
  output logic [8:0]         addra,
  output logic [DIST_W-1:0]  dina,
  output logic               frame_rdy,
  output logic [7:0]         drop_cnt
);

  import tof_pkg::*;

  localparam logic [CNT_W-1:0]   ZONES_C   = CNT_W'(ZONES);
  localparam logic [CNT_W-1:0]   LAST_C    = CNT_W'(ZONES - 1);
  localparam logic [NUM_TOF-1:0] ACK_ONE_C = {{(NUM_TOF-1){1'b0}}, 1'b1};

  fw_state_e           state_q, state_d;
  logic [2:0]          sel_q, sel_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q [NUM_TOF];
  logic [CNT_W-1:0]    cnt_d [NUM_TOF];
  logic [7:0]          drop_q, drop_d;
  logic                frame_rdy_q, frame_rdy_d;

  logic [2:0]          grant_s;
  logic                grant_valid_s;
  logic [CNT_W-1:0]    cur_cnt_s;
  logic                room_s;
  logic                others_full_s;
  logic                wea_s;
  logic [NUM_TOF-1:0]  ack_s;
  logic [8:0]          addra_s;
  logic [DIST_W-1:0]   dina_s;

  rr_arbiter8 u_arb (
    .req   (tof_rdy),
    .ptr   (ptr_q),
    .grant (grant_s),
    .valid (grant_valid_s)
  );

  // Count of the selected sensor and whether every other sensor is full;
  // together they tell whether this write completes the frame.
  always_comb begin
    cur_cnt_s     = cnt_q[sel_q];
    room_s        = (cur_cnt_s < ZONES_C);
    others_full_s = 1'b1;
    for (int i = 0; i < NUM_TOF; i++) begin
      others_full_s = others_full_s & ((3'(i) == sel_q) || (cnt_q[i] == ZONES_C));
    end
  end

  // Next-state, counters and the combinational port-A write of the WRITE cycle.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    frame_rdy_d = frame_rdy_q;
    wea_s       = 1'b0;
    ack_s       = '0;
    addra_s     = 9'd0;
    dina_s      = '0;
    case (state_q)
      ST_SCAN: begin
        if (grant_valid_s) begin
          sel_d   = grant_s;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_WRITE: begin
        // The word is popped whether it is stored or dropped.
        ack_s = ACK_ONE_C << sel_q;
        ptr_d = sel_q + 3'd1;
        if (room_s) begin
          wea_s        = 1'b1;
          addra_s      = {sel_q, tof_data[ZONE_MSB:ZONE_LSB]};
          dina_s       = tof_data[DIST_MSB:DIST_LSB];
          cnt_d[sel_q] = cur_cnt_s + 7'd1;
          if (others_full_s && (cur_cnt_s == LAST_C)) begin
            state_d     = ST_HOLD;
            frame_rdy_d = 1'b1;
          end else begin
            state_d     = ST_SCAN;
          end
        end else begin
          drop_d  = (drop_q == 8'hFF) ? drop_q : (drop_q + 8'd1);
          state_d = ST_SCAN;
        end
      end
      ST_HOLD: begin
        if (frame_ack) begin
          state_d     = ST_SCAN;
          frame_rdy_d = 1'b0;
          for (int i = 0; i < NUM_TOF; i++) begin
            cnt_d[i] = '0;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  // State, selection, round-robin pointer, counters and drop count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      sel_q       <= 3'd0;
      ptr_q       <= 3'd0;
      drop_q      <= 8'd0;
      frame_rdy_q <= 1'b0;
      for (int i = 0; i < NUM_TOF; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      drop_q      <= drop_d;
      frame_rdy_q <= frame_rdy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign tof_sel   = sel_q;
  assign tof_ack   = ack_s;
  assign wea       = wea_s;
  assign addra     = addra_s;
  assign dina      = dina_s;
  assign frame_rdy = frame_rdy_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_tof_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_tof_frame_writer
// Randomized bench for tof_frame_writer. Sensors are modelled as word queues;
// a transaction-level reference (per-sensor word counts, drop count, round-
// robin pointer, frame-complete flag) predicts the outputs of every cycle.
// Output bundle layout: {ack[45:38], wea[37], addra[36:28], dina[27:12],
// frame_rdy[11], drop_cnt[10:3], tof_sel[2:0]}.
// ---------------------------------------------------------------------------
module tb_tof_frame_writer;

  logic        clk;
  logic        reset;
  logic [7:0]  tof_rdy;
  logic [21:0] tof_data;
  logic        frame_ack;
  logic [2:0]  tof_sel;
  logic [7:0]  tof_ack;
  logic        wea;
  logic [8:0]  addra;
  logic [15:0] dina;
  logic        frame_rdy;
  logic [7:0]  drop_cnt;

  tof_frame_writer dut (
    .clk       (clk),
    .reset     (reset),
    .tof_rdy   (tof_rdy),
    .tof_data  (tof_data),
    .frame_ack (frame_ack),
    .tof_sel   (tof_sel),
    .tof_ack   (tof_ack),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .frame_rdy (frame_rdy),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sensor word queues and the upstream mux steered by tof_sel.
  logic [21:0] sq [8][$];
  logic [21:0] head [8];
  assign tof_data = head[tof_sel];

  // Reference model state.
  int m_cnt [8];
  int m_drops;
  int m_ptr;
  int m_sel;
  bit m_write;
  bit m_full;

  int nvec;
  int nerr;

  task automatic refresh();
    for (int i = 0; i < 8; i++) begin
      tof_rdy[i] = (sq[i].size() > 0);
      head[i]    = (sq[i].size() > 0) ? sq[i][0] : 22'd0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_drops = 0;
    m_ptr   = 0;
    m_sel   = 0;
    m_write = 1'b0;
    m_full  = 1'b0;
  endtask

  function automatic int pick(input int p, input logic [7:0] r);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return 0;
  endfunction

  task automatic do_reset(input bit clr);
    reset     = 1'b1;
    frame_ack = 1'b0;
    if (clr) begin
      for (int i = 0; i < 8; i++) sq[i].delete();
    end
    refresh();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic feed_one(input int s);
    if (sq[s].size() == 0) sq[s].push_back({6'($urandom_range(0, 63)), 16'($urandom)});
    refresh();
  endtask

  task automatic feed_random();
    for (int i = 0; i < 8; i++) begin
      if (sq[i].size() == 0) begin
        if ((m_cnt[i] < 64) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 31) == 0))
          sq[i].push_back({6'($urandom_range(0, 63)), 16'($urandom)});
      end
    end
    refresh();
  endtask

  // Advance the model across the next rising edge using the inputs now
  // applied, predict the following cycle, then sample the DUT at the negedge.
  task automatic cycle(output logic [45:0] e, output logic [45:0] a);
    logic [21:0] w;
    logic [7:0]  ea;
    bit          room;
    bit          all_full;
    if (m_write) begin
      if (m_cnt[m_sel] < 64) m_cnt[m_sel]++;
      else if (m_drops < 255) m_drops++;
      m_ptr = (m_sel + 1) % 8;
      void'(sq[m_sel].pop_front());
      refresh();
      m_write  = 1'b0;
      all_full = 1'b1;
      for (int i = 0; i < 8; i++) if (m_cnt[i] != 64) all_full = 1'b0;
      m_full   = all_full;
    end else if (m_full) begin
      if (frame_ack) begin
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_full = 1'b0;
      end
    end else if (tof_rdy != 8'd0) begin
      m_sel   = pick(m_ptr, tof_rdy);
      m_write = 1'b1;
    end
    if (m_write) begin
      w    = sq[m_sel][0];
      room = (m_cnt[m_sel] < 64);
      ea   = 8'd1 << m_sel;
      e    = {ea, room, room ? {3'(m_sel), w[21:16]} : 9'd0, room ? w[15:0] : 16'd0,
              1'b0, 8'(m_drops), 3'(m_sel)};
    end else begin
      e    = {8'd0, 1'b0, 9'd0, 16'd0, m_full, 8'(m_drops), 3'(m_sel)};
    end
    @(negedge clk);
    a = {tof_ack, wea, wea ? addra : 9'd0, ((tof_ack != 8'd0) && !wea) ? 16'd0 : dina,
         frame_rdy, drop_cnt, tof_sel};
  endtask

  task automatic test_reset();
    logic [45:0] e, a;
    reset     = 1'b1;
    frame_ack = 1'b0;
    refresh();
    #1;
    nvec++;
    if ({tof_ack, wea, addra, dina, frame_rdy, drop_cnt, tof_sel} !== 46'd0) begin
      nerr++;
      $display("FAIL reset_values: got %h expected 0", {tof_ack, wea, addra, dina, frame_rdy, drop_cnt, tof_sel});
    end
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(e, a);
      nvec++;
      if (a !== e) begin nerr++; $display("FAIL reset_idle cyc %0d: got %h expected %h", i, a, e); end
    end
  endtask

  task automatic test_single();
    logic [45:0] e, a;
    do_reset(1'b1);
    sq[0].push_back({6'd5, 16'h1234});
    refresh();
    for (int i = 0; i < 4; i++) begin
      cycle(e, a);
      nvec++;
      if (a !== e) begin nerr++; $display("FAIL single cyc %0d: got %h expected %h", i, a, e); end
      if (i == 0) begin
        nvec++;
        if ({tof_ack, wea, addra, dina} !== {8'h01, 1'b1, 9'h005, 16'h1234}) begin
          nerr++;
          $display("FAIL single_write: got %h expected %h", {tof_ack, wea, addra, dina}, {8'h01, 1'b1, 9'h005, 16'h1234});
        end
      end
    end
  endtask

  task automatic test_fairness();
    logic [45:0] e, a;
    int order[$];
    int last_c;
    do_reset(1'b1);
    for (int s = 0; s < 8; s++) feed_one(s);
    last_c = -1;
    for (int c = 0; c < 18; c++) begin
      cycle(e, a);
      nvec++;
      if (a !== e) begin nerr++; $display("FAIL fair cyc %0d: got %h expected %h", c, a, e); end
      if (tof_ack != 8'd0) begin
        for (int b = 0; b < 8; b++) if (tof_ack[b]) order.push_back(b);
        if (last_c >= 0) begin
          nvec++;
          if (c - last_c != 2) begin nerr++; $display("FAIL fair_gap: got %0d expected 2", c - last_c); end
        end
        last_c = c;
      end
      for (int s = 0; s < 8; s++) feed_one(s);
    end
    nvec++;
    if (order.size() != 9) begin nerr++; $display("FAIL fair_count: got %0d expected 9", order.size()); end
    for (int j = 0; j < order.size(); j++) begin
      nvec++;
      if (order[j] != j % 8) begin nerr++; $display("FAIL fair_order %0d: got %0d expected %0d", j, order[j], j % 8); end
    end
  endtask

  task automatic test_full_frame();
    logic [45:0] e, a;
    int wcount, guard;
    do_reset(1'b1);
    wcount = 0;
    guard  = 0;
    while (!frame_rdy && guard < 6000) begin
      feed_random();
      cycle(e, a);
      nvec++;
      if (a !== e) begin nerr++; $display("FAIL frame cyc %0d: got %h expected %h", guard, a, e); end
      if (wea) wcount++;
      guard++;
    end
    nvec++;
    if (frame_rdy !== 1'b1 || wcount != 512) begin
      nerr++;
      $display("FAIL frame_done: got frame_rdy=%b writes=%0d expected 1 512", frame_rdy, wcount);
    end
    for (int s = 0; s < 8; s++) feed_one(s);
    for (int c = 0; c < 6; c++) begin
      cycle(e, a);
      nvec++;
      if (a !== e || tof_ack !== 8'd0 || wea !== 1'b0) begin
        nerr++;
        $display("FAIL hold cyc %0d: got %h expected %h", c, a, e);
      end
    end
    frame_ack = 1'b1;
    cycle(e, a);
    frame_ack = 1'b0;
    nvec++;
    if (a !== e || frame_rdy !== 1'b0) begin nerr++; $display("FAIL frame_ack: got %h expected %h", a, e); end
    wcount = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(e, a);
      nvec++;
      if (a !== e) begin nerr++; $display("FAIL resume cyc %0d: got %h expected %h", c, a, e); end
      if (wea) wcount++;
      feed_random();
    end
    nvec++;
    if (wcount == 0) begin nerr++; $display("FAIL resume_writes: got 0 expected >0"); end
  endtask

  task automatic test_overflow();
    logic [45:0] e, a;
    int n3;
    do_reset(1'b1);
    n3 = 0;
    for (int c = 0; c < 740; c++) begin
      feed_one(3);
      cycle(e, a);
      nvec++;
      if (a !== e) begin nerr++; $display("FAIL ovf cyc %0d: got %h expected %h", c, a, e); end
      if (tof_ack[3]) begin
        n3++;
        if (n3 == 65) begin
          nvec++;
          if (wea !== 1'b0) begin nerr++; $display("FAIL ovf_65_wea: got %b expected 0", wea); end
        end
        if (n3 == 66) begin
          nvec++;
          if (drop_cnt !== 8'd1) begin nerr++; $display("FAIL ovf_drop1: got %0d expected 1", drop_cnt); end
        end
      end
    end
    nvec++;
    if (drop_cnt !== 8'd255) begin nerr++; $display("FAIL ovf_sat: got %0d expected 255", drop_cnt); end
  endtask

  task automatic test_ack_in_scan();
    logic [45:0] e, a;
    int n3, pushed;
    do_reset(1'b1);
    n3     = 0;
    pushed = 0;
    for (int c = 0; c < 200 && n3 < 65; c++) begin
      if (sq[3].size() == 0 && (pushed < 10 || (pushed < 65 && n3 >= 10 && c > 30))) begin
        feed_one(3);
        pushed++;
      end
      if (c == 28) frame_ack = 1'b1;
      cycle(e, a);
      frame_ack = 1'b0;
      nvec++;
      if (a !== e) begin nerr++; $display("FAIL scan_ack cyc %0d: got %h expected %h", c, a, e); end
      if (tof_ack[3]) begin
        n3++;
        nvec++;
        if (wea !== ((n3 <= 64) ? 1'b1 : 1'b0)) begin
          nerr++;
          $display("FAIL scan_ack_wea word %0d: got %b expected %b", n3, wea, (n3 <= 64));
        end
      end
    end
    nvec++;
    if (n3 != 65) begin nerr++; $display("FAIL scan_ack_count: got %0d expected 65", n3); end
  endtask

  task automatic test_reset_mid();
    logic [45:0] e, a;
    int wcount, guard;
    do_reset(1'b1);
    wcount = 0;
    guard  = 0;
    while (wcount < 100 && guard < 2000) begin
      feed_random();
      cycle(e, a);
      nvec++;
      if (a !== e) begin nerr++; $display("FAIL mid cyc %0d: got %h expected %h", guard, a, e); end
      if (wea) wcount++;
      guard++;
    end
    reset = 1'b1;
    #1;
    nvec++;
    if ({tof_ack, wea, addra, dina, frame_rdy, drop_cnt, tof_sel} !== 46'd0) begin
      nerr++;
      $display("FAIL mid_reset_now: got %h expected 0", {tof_ack, wea, addra, dina, frame_rdy, drop_cnt, tof_sel});
    end
    for (int s = 0; s < 8; s++) feed_one(s);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      nvec++;
      if (tof_ack !== 8'd0 || wea !== 1'b0) begin
        nerr++;
        $display("FAIL mid_reset_held: got ack=%h wea=%b expected 00 0", tof_ack, wea);
      end
    end
    model_reset();
    reset  = 1'b0;
    wcount = 0;
    guard  = 0;
    while (!frame_rdy && guard < 6000) begin
      feed_random();
      cycle(e, a);
      nvec++;
      if (a !== e) begin nerr++; $display("FAIL refill cyc %0d: got %h expected %h", guard, a, e); end
      if (wea) wcount++;
      guard++;
    end
    nvec++;
    if (frame_rdy !== 1'b1 || wcount != 512) begin
      nerr++;
      $display("FAIL refill_done: got frame_rdy=%b writes=%0d expected 1 512", frame_rdy, wcount);
    end
  endtask

  initial begin
    nvec      = 0;
    nerr      = 0;
    reset     = 1'b1;
    frame_ack = 1'b0;
    tof_rdy   = 8'd0;
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_full_frame();
    test_overflow();
    test_ack_in_scan();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tof_frame_writer.md
TOF_FRAME_WRITER -- requirements
Module: tof_frame_writer

Interface
REQ-001 Parameter NUM_TOF, default 8: number of ToF sensors; fixed at 8 in this revision.
REQ-002 Parameter ZONES, default 64: distance words per sensor per frame.
REQ-003 Parameter DIST_W, default 16: distance word width.
REQ-004 Port clk  input  1: single clock; all logic on its rising edge.
REQ-005 Port reset  input  1: asynchronous, active-high reset.
REQ-006 Port tof_rdy  input  8: per-sensor level flag; word pending; held until acked.
REQ-007 Port tof_data  input  22: [21:16] zone index, [15:0] distance; valid for sensor tof_sel.
REQ-008 Port frame_ack  input  1: one-cycle pulse from the read FSM; frame fully consumed.
REQ-009 Port tof_sel  output  3: sensor index driving the upstream data mux.
REQ-010 Port tof_ack  output  8: one-hot, one-cycle pop to the selected sensor.
REQ-011 Port wea  output  1: BRAM port-A write enable.
REQ-012 Port addra  output  9: BRAM address {tof_sel, zone}.
REQ-013 Port dina  output  16: BRAM write data.
REQ-014 Port frame_rdy  output  1: level; all 8x64 words written.
REQ-015 Port drop_cnt  output  8: saturating count of discarded words.

Function
REQ-016 The block SHALL implement states SCAN, WRITE and HOLD.
REQ-017 In SCAN, if any tof_rdy bit is set for a non-complete or complete sensor, the block SHALL register tof_sel = first set bit at or after rr_ptr (wrapping 7->0) and go to WRITE; otherwise it SHALL stay in SCAN.
REQ-018 In WRITE, the block SHALL assert tof_ack[tof_sel] for exactly one cycle and return to SCAN, giving a throughput of one word per 2 cycles.
REQ-019 In WRITE, if sensor tof_sel has fewer than ZONES words counted, the block SHALL assert wea with addra={tof_sel,tof_data[21:16]} and dina=tof_data[15:0] combinationally in that cycle, and increment that sensor's 7-bit count.
REQ-020 In WRITE, if sensor tof_sel already holds ZONES words, the block SHALL keep wea=0, still ack, and increment drop_cnt, saturating at 255.
REQ-021 rr_ptr SHALL update to tof_sel+1 (mod 8) on every WRITE.
REQ-022 When the WRITE that brings the last incomplete count to ZONES completes, the block SHALL enter HOLD the next cycle, with frame_rdy=1 from that cycle.
REQ-023 In HOLD, the block SHALL ignore tof_rdy (no ack, no wea) and keep frame_rdy=1.
REQ-024 frame_ack in HOLD SHALL clear all counts and frame_rdy, return to SCAN next cycle, and leave rr_ptr and drop_cnt unchanged; tof_rdy set in the same cycle SHALL be served from the following SCAN.
REQ-025 frame_ack outside HOLD SHALL be ignored.
REQ-026 Duplicate zone indices SHALL be written and counted without checking.
REQ-027 wea, tof_ack and dina SHALL be 0 in any cycle that is not WRITE.

Reset
REQ-028 Reset SHALL asynchronously force SCAN, tof_sel=0, rr_ptr=0, all counts=0, frame_rdy=0, drop_cnt=0, wea=0, tof_ack=0, addra=0, dina=0.
REQ-029 Reset mid-frame SHALL discard partial counts; no write or ack SHALL occur while reset is high.

Structure
REQ-030 A shared package tof_pkg SHALL hold NUM_TOF, ZONES, DIST_W, the zone/distance field positions and the state encoding.
REQ-031 The round-robin pick SHALL be a sub-module rr_arbiter8 (inputs req[7:0] and ptr[2:0], outputs grant index and valid).

Verification
REQ-032 Single sensor: tof_rdy=8'h01, zone 5, dist 16'h1234 -> WRITE 2 cycles after rdy rises (SCAN then WRITE), wea=1, addra=9'h005, dina=16'h1234, tof_ack=8'h01.
REQ-033 Fairness: tof_rdy=8'hFF held -> ack order 0,1,...,7,0; a new grant every 2 cycles.
REQ-034 Full frame: 512 words, 64 per sensor -> frame_rdy=1 one cycle after the 512th write; further tof_rdy is not acked; frame_ack -> counts cleared, frame_rdy=0, writes resume.
REQ-035 Overflow: a 65th word to sensor 3 before the frame completes -> acked, wea=0, drop_cnt=1; after 300 such words drop_cnt stays at 255.
REQ-036 Reset mid-frame after 100 writes -> all outputs 0 immediately; frame_rdy requires a full 512 new words.
REQ-037 frame_ack pulsed in SCAN after 10 writes -> no effect; counts preserved.
